// File: rtl/pc_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared definitions for the IF-stage program counter sequencer:
//   - default reset PC (MARS text base) and address width
//   - FSM state encoding (ST_RUN / ST_HELD)
//   - redirect-source select codes produced by pc_redirect_mux
//   - small helpers for alignment checking and saturating counters
// -----------------------------------------------------------------------------
package pc_sequencer_pkg;

    localparam int          ADDR_W_DEFAULT   = 32;
    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;

    // RUN: no buffered redirect. HELD: a redirect target waits for imem_ready.
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HELD = 1'b1
    } pc_state_e;

    // Which D-stage source (if any) supplies the next-PC target this cycle.
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_BR   = 2'd1,
        SEL_J    = 2'd2,
        SEL_JR   = 2'd3
    } redir_sel_e;

    // A word address must have its two low bits clear.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        is_misaligned = (low_bits != 2'b00);
    endfunction

    // Increment by one when enabled, sticking at the all-ones value.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic        en);
        if (en && (value != CNT_MAX)) begin
            sat_inc = value + 32'd1;
        end else begin
            sat_inc = value;
        end
    endfunction

endpackage : pc_sequencer_pkg

// File: rtl/pc_redirect_mux.sv
// -----------------------------------------------------------------------------
// pc_redirect_mux
// Combinational next-PC redirect selection for the IF stage.
//   Priority: jr > j > (branch valid & taken). Branch valid but not taken is
//   not a redirect. Nothing is selected while en is low (the sequencer drops
//   en during a stall, or while a redirect is already buffered).
//   The chosen target is forced word-aligned; misaligned flags an accepted jr
//   whose register target had non-zero low bits.
// Ports:
//   en          in   1       redirects may be accepted this cycle
//   br_valid    in   1       branch instruction in D
//   br_taken    in   1       D-stage compare result
//   br_target   in   ADDR_W  branch target
//   j_valid     in   1       j/jal in D
//   j_target    in   ADDR_W  jump target
//   jr_valid    in   1       jr/jalr in D
//   jr_target   in   ADDR_W  register target
//   sel         out  2       selected source (SEL_NONE when no redirect)
//   target      out  ADDR_W  selected target with low 2 bits cleared
//   misaligned  out  1       selected source is jr and its target was unaligned
// -----------------------------------------------------------------------------
module pc_redirect_mux
    import pc_sequencer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              en,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              j_valid,
    input  logic [ADDR_W-1:0] j_target,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_target,
    output redir_sel_e        sel,
    output logic [ADDR_W-1:0] target,
    output logic              misaligned
);

    logic [ADDR_W-1:0] raw_target_s;

    // Priority select of the redirect source.
    always_comb begin
        sel = SEL_NONE;
        if (!en) begin
            sel = SEL_NONE;
        end else if (jr_valid) begin
            sel = SEL_JR;
        end else if (j_valid) begin
            sel = SEL_J;
        end else if (br_valid && br_taken) begin
            sel = SEL_BR;
        end else begin
            sel = SEL_NONE;
        end
    end

    // Route the selected source's target.
    always_comb begin
        raw_target_s = '0;
        case (sel)
            SEL_JR:  raw_target_s = jr_target;
            SEL_J:   raw_target_s = j_target;
            SEL_BR:  raw_target_s = br_target;
            default: raw_target_s = '0;
        endcase
    end

    assign target     = {raw_target_s[ADDR_W-1:2], 2'b00};
    // Only jr carries a register-sourced address that can be unaligned.
    assign misaligned = (sel == SEL_JR) && is_misaligned(raw_target_s[1:0]);

endmodule : pc_redirect_mux

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Owns the IF-stage program counter of the 5-stage MIPS pipeline.
//   Next PC is PC+4 or a D-stage redirect (jr > j > taken branch). The PC
//   advances only when the hazard unit is not stalling and instruction memory
//   has delivered the current word. A redirect seen while IM is busy is
//   buffered (state HELD) and applied on the next advance; further redirects
//   during HELD are ignored because the delay-slot fetch cannot produce a
//   second control instruction before the first one completes.
//   No flush is generated: the delay-slot instruction is kept.
// Ports:
//   clk            in   1       rising-edge clock
//   reset          in   1       synchronous, active-high
//   stall          in   1       freeze PC and IF/ID; redirects ignored
//   imem_ready     in   1       IM has the word for pc
//   br_valid       in   1       branch in D
//   br_taken       in   1       branch compare result
//   br_target      in   ADDR_W  branch target
//   j_valid        in   1       j/jal in D
//   j_target       in   ADDR_W  jump target
//   jr_valid       in   1       jr/jalr in D
//   jr_target      in   ADDR_W  register target
//   pc             out  ADDR_W  current fetch address
//   pc_plus4       out  ADDR_W  pc + 4 (wraps)
//   if_valid       out  1       IF/ID may capture (~stall & imem_ready)
//   redir_pending  out  1       a redirect is buffered
//   adel           out  1       one-cycle pulse after accepting an unaligned jr
// Build option PC_SEQ_PERF_EN adds:
//   stall_cnt      out  32      cycles without advance (saturating)
//   redir_cnt      out  32      accepted redirects (saturating)
// -----------------------------------------------------------------------------
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = ADDR_W_DEFAULT,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              imem_ready,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              j_valid,
    input  logic [ADDR_W-1:0] j_target,
    input  logic              jr_valid,
    input  logic [ADDR_W-1:0] jr_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              if_valid,
    output logic              redir_pending,
    output logic              adel
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       redir_cnt
`endif
);

    pc_state_e         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] held_target_q;
    logic              adel_q;

    logic              adv_s;
    logic              accept_en_s;
    logic              accept_s;
    redir_sel_e        sel_s;
    logic [ADDR_W-1:0] target_s;
    logic              misaligned_s;
    logic [ADDR_W-1:0] pc_plus4_s;

    assign adv_s       = ~stall & imem_ready;
    // A stalled D instruction will be re-presented, and HELD already owns
    // the next redirect, so acceptance is limited to unstalled RUN cycles.
    assign accept_en_s = ~stall & (state_q == ST_RUN);
    assign accept_s    = (sel_s != SEL_NONE);
    // Natural modulo-2^ADDR_W wrap from the adder width.
    assign pc_plus4_s  = pc_q + ADDR_W'(3'd4);

    pc_redirect_mux #(
        .ADDR_W (ADDR_W)
    ) u_redirect_mux (
        .en         (accept_en_s),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .j_valid    (j_valid),
        .j_target   (j_target),
        .jr_valid   (jr_valid),
        .jr_target  (jr_target),
        .sel        (sel_s),
        .target     (target_s),
        .misaligned (misaligned_s)
    );

    // PC / redirect-buffer FSM with registered pc, pending and adel.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            held_target_q <= '0;
            adel_q        <= 1'b0;
        end else begin
            adel_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (adv_s) begin
                        pc_q   <= accept_s ? target_s : pc_plus4_s;
                        adel_q <= accept_s & misaligned_s;
                    end else if (accept_s) begin
                        // IM busy: keep the target until the fetch completes.
                        held_target_q <= target_s;
                        state_q       <= ST_HELD;
                        adel_q        <= misaligned_s;
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                ST_HELD: begin
                    if (adv_s) begin
                        pc_q          <= held_target_q;
                        held_target_q <= '0;
                        state_q       <= ST_RUN;
                    end else begin
                        pc_q <= pc_q;
                    end
                end
                default: begin
                    state_q       <= ST_RUN;
                    held_target_q <= '0;
                end
            endcase
        end
    end

    assign pc            = pc_q;
    assign pc_plus4      = pc_plus4_s;
    assign if_valid      = adv_s;
    assign redir_pending = (state_q == ST_HELD);
    assign adel          = adel_q;

`ifdef PC_SEQ_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] redir_cnt_q;
    logic [31:0] redir_cnt_d;

    // Next values of the saturating performance counters.
    always_comb begin
        stall_cnt_d = sat_inc(stall_cnt_q, ~adv_s);
        redir_cnt_d = sat_inc(redir_cnt_q, accept_s);
    end

    // Performance counter registers; reset cycles are not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign redir_cnt = redir_cnt_q;
`endif

endmodule : pc_sequencer
